ldr_upload: RTL

- HPS-side upload bridge. The core's memory image (SRAM/ROM regions) is read back over the HPS ioctl upload channel.
- It is the read-direction counterpart of the loader write path (`ioctl_wr` → `ldr_wr`/`ldr_ack` → `X68K_top`).
- It sits beside `hps_io` in the emu top level:
  - converts byte-wide `ioctl_rd` requests into 16-bit word reads on the `X68K_top` loader port;
  - holds the HPS off with `ioctl_wait` while a word is being fetched;
  - caches one word so that consecutive byte reads of the same word cost one fetch.

---
 rtl/ldr_upload.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ldr_upload.sv
// ldr_upload: HPS upload bridge. Turns byte-wide ioctl read strobes into
// 16-bit word reads on the loader port. A one-word cache lets the second
// byte of a word be returned without another fetch.
module ldr_upload #(
    parameter int AW         = 20,
    parameter int SIZE       = 1048576,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TIMEOUT    = 4095
) (
    input  logic          clk_sys,
    input  logic          rstn,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          mem_aen,
    output logic [AW-2:0] mem_addr,
    output logic          mem_rd,
    input  logic          mem_ack,
    input  logic [15:0]   mem_rdat,
    output logic          up_done,
    output logic          up_err
);

    localparam logic       STATE_IDLE  = 1'b0;
    localparam logic       STATE_FETCH = 1'b1;
    localparam logic [25:0] SIZE_L     = 26'(SIZE);
    localparam logic [15:0] TIMEOUT_L  = 16'(TIMEOUT);

    // Picks the requested byte out of a word. An even byte address maps to
    // the high byte in 68000 order and to the low byte otherwise.
    function automatic logic [7:0] sel_byte(input logic [15:0] word, input logic odd);
        logic [7:0] b;
        if ((odd ^ BIG_ENDIAN) == 1'b1) begin
            b = word[15:8];
        end else begin
            b = word[7:0];
        end
        return b;
    endfunction

    // Registered state
    logic          r_state;
    logic          r_upload_d;
    logic          r_ack_d;
    logic [15:0]   r_cnt;
    logic          r_cache_vld;
    logic [AW-2:0] r_cache_tag;
    logic [15:0]   r_cache_word;
    logic          r_byte_sel;
    logic [7:0]    r_din;
    logic          r_wait;
    logic          r_mem_rd;
    logic [AW-2:0] r_mem_addr;
    logic          r_done;
    logic          r_err;

    // Next-state values
    logic          w_state_nxt;
    logic [15:0]   w_cnt_nxt;
    logic          w_cache_vld_nxt;
    logic [AW-2:0] w_cache_tag_nxt;
    logic [15:0]   w_cache_word_nxt;
    logic          w_byte_sel_nxt;
    logic [7:0]    w_din_nxt;
    logic          w_wait_nxt;
    logic          w_mem_rd_nxt;
    logic [AW-2:0] w_mem_addr_nxt;
    logic          w_done_nxt;
    logic          w_err_nxt;

    // Decoded events
    logic          w_up_rise;
    logic          w_up_fall;
    logic          w_ack_rise;
    logic          w_req;
    logic          w_oor;
    logic          w_hit;
    logic [AW-2:0] w_word_addr;
    logic [15:0]   w_cnt_inc;

    assign w_up_rise   = ioctl_upload & ~r_upload_d;
    assign w_up_fall   = ~ioctl_upload & r_upload_d;
    assign w_ack_rise  = mem_ack & ~r_ack_d;
    assign w_req       = ioctl_rd & ioctl_upload & ~r_done;
    assign w_word_addr = ioctl_addr[AW-1:1];
    assign w_oor       = ({1'b0, ioctl_addr} >= SIZE_L);
    // A session start invalidates the cache on this same edge, so never hit on it.
    assign w_hit       = r_cache_vld & ~w_up_rise & (r_cache_tag == w_word_addr);
    assign w_cnt_inc   = r_cnt + 16'd1;

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign mem_addr   = r_mem_addr;
    assign mem_rd     = r_mem_rd;
    assign up_done    = r_done;
    assign up_err     = r_err;
    assign mem_aen    = ioctl_upload & ~r_done;

    // Session edges take priority over the read state machine; a session end
    // abandons any outstanding fetch without touching the returned byte.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_cache_vld_nxt  = r_cache_vld;
        w_cache_tag_nxt  = r_cache_tag;
        w_cache_word_nxt = r_cache_word;
        w_byte_sel_nxt   = r_byte_sel;
        w_din_nxt        = r_din;
        w_wait_nxt       = r_wait;
        w_mem_rd_nxt     = r_mem_rd;
        w_mem_addr_nxt   = r_mem_addr;
        w_done_nxt       = r_done;
        w_err_nxt        = r_err;

        if (w_up_fall) begin
            w_done_nxt   = 1'b1;
            w_mem_rd_nxt = 1'b0;
            w_wait_nxt   = 1'b0;
            w_state_nxt  = STATE_IDLE;
        end else if (w_up_rise) begin
            w_done_nxt      = 1'b0;
            w_err_nxt       = 1'b0;
            w_cache_vld_nxt = 1'b0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    if (w_req) begin
                        if (w_oor) begin
                            w_din_nxt = 8'hFF;
                        end else if (w_hit) begin
                            w_din_nxt = sel_byte(r_cache_word, ioctl_addr[0]);
                        end else begin
                            w_wait_nxt     = 1'b1;
                            w_mem_rd_nxt   = 1'b1;
                            w_mem_addr_nxt = w_word_addr;
                            w_byte_sel_nxt = ioctl_addr[0];
                            w_cnt_nxt      = 16'd0;
                            w_state_nxt    = STATE_FETCH;
                        end
                    end else begin
                        w_state_nxt = STATE_IDLE;
                    end
                end
                STATE_FETCH: begin
                    // Strobes arriving here are dropped: the HPS honours wait.
                    if (w_ack_rise) begin
                        w_cache_word_nxt = mem_rdat;
                        w_cache_tag_nxt  = r_mem_addr;
                        w_cache_vld_nxt  = 1'b1;
                        w_din_nxt        = sel_byte(mem_rdat, r_byte_sel);
                        w_mem_rd_nxt     = 1'b0;
                        w_wait_nxt       = 1'b0;
                        w_state_nxt      = STATE_IDLE;
                    end else if (w_cnt_inc == TIMEOUT_L) begin
                        w_din_nxt       = 8'hFF;
                        w_err_nxt       = 1'b1;
                        w_cache_vld_nxt = 1'b0;
                        w_mem_rd_nxt    = 1'b0;
                        w_wait_nxt      = 1'b0;
                        w_state_nxt     = STATE_IDLE;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt  = STATE_IDLE;
                    w_mem_rd_nxt = 1'b0;
                    w_wait_nxt   = 1'b0;
                end
            endcase
        end
    end

    // State register with asynchronous reset to the idle, all-invalid state.
    always_ff @(posedge clk_sys or negedge rstn) begin
        if (!rstn) begin
            r_state      <= STATE_IDLE;
            r_upload_d   <= 1'b0;
            r_ack_d      <= 1'b0;
            r_cnt        <= 16'd0;
            r_cache_vld  <= 1'b0;
            r_cache_tag  <= '0;
            r_cache_word <= 16'h0000;
            r_byte_sel   <= 1'b0;
            r_din        <= 8'hFF;
            r_wait       <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_addr   <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_upload_d   <= ioctl_upload;
            r_ack_d      <= mem_ack;
            r_cnt        <= w_cnt_nxt;
            r_cache_vld  <= w_cache_vld_nxt;
            r_cache_tag  <= w_cache_tag_nxt;
            r_cache_word <= w_cache_word_nxt;
            r_byte_sel   <= w_byte_sel_nxt;
            r_din        <= w_din_nxt;
            r_wait       <= w_wait_nxt;
            r_mem_rd     <= w_mem_rd_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

endmodule
